cook_sequencer: RTL and testbench
=================================

COOK_SEQUENCER -- requirements
Module: cook_sequencer

Interface
REQ-001 Parameter CLK_PER_SEC, default 50000000, clock cycles per countdown second (bench uses 4).
REQ-002 clock  in  1  system clock (CLOCK_50 at top level).
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle pulse: begin, or resume, cooking.
REQ-005 stop  in  1  one-cycle pulse: pause, cancel, or acknowledge done.
REQ-006 door_open  in  1  level, door interlock.
REQ-007 duration_bcd  in  16  cook time MMSS as four BCD digits [15:12]=M tens ... [3:0]=S units.
REQ-008 heat_level  in  2  power setting 0..3.
REQ-009 heater_pwm  out  1  registered heater drive.
REQ-010 motor_on  out  1  turntable enable, high in COOK only.
REQ-011 remaining_bcd  out  16  live countdown, BCD MMSS.
REQ-012 busy  out  1  high in LOAD, COOK, PAUSE.
REQ-013 done  out  1  level, high in DONE only.
REQ-014 err  out  1  one-cycle pulse on a rejected start.
REQ-015 state  out  3  encoded FSM state for HEX display.

Function
REQ-016 FSM states and encodings SHALL be IDLE=0, LOAD=1, COOK=2, PAUSE=3, DONE=4.
REQ-017 In IDLE, start with door closed, valid BCD and nonzero duration SHALL go to LOAD next cycle.
REQ-018 Valid BCD SHALL mean every digit is 9 or less and the seconds-tens digit is 5 or less.
REQ-019 In IDLE, a start with invalid or zero duration SHALL pulse err for one cycle and stay in IDLE.
REQ-020 In IDLE, a start while door_open is high SHALL be ignored, with no err.
REQ-021 LOAD SHALL capture duration_bcd into remaining_bcd and heat_level into an internal register, clear the prescaler, and go to COOK after one cycle.
REQ-022 heat_level changes after LOAD SHALL have no effect until the next LOAD.
REQ-023 In COOK, the prescaler SHALL count 0..CLK_PER_SEC-1 and emit a tick on the terminal count.
REQ-024 Each tick SHALL decrement remaining_bcd by one second with BCD borrow: S units 0 -> 9, S tens 0 -> 5, M units 0 -> 9.
REQ-025 The tick that makes remaining_bcd reach 0000 SHALL move the FSM to DONE on the same clock edge.
REQ-026 In COOK, stop or door_open SHALL go to PAUSE next cycle.
REQ-027 PAUSE SHALL hold both remaining_bcd and the prescaler count, preserving the partial second.
REQ-028 In PAUSE, start with door closed SHALL resume COOK without reloading.
REQ-029 In PAUSE, stop SHALL go to IDLE and clear remaining_bcd to 0000.
REQ-030 In DONE, start or stop SHALL go to IDLE and clear remaining_bcd to 0000.
REQ-031 When start and stop occur in the same cycle, stop SHALL win in every state.
REQ-032 An 8-bit PWM counter SHALL free-run in COOK and be held at 0 in all other states.
REQ-033 heater_pwm SHALL be high when the PWM counter is below the threshold for the latched level: 64, 128 or 192 for levels 0-2; level 3 is always high.
REQ-034 heater_pwm SHALL be low, registered, one cycle after leaving COOK.
REQ-035 motor_on SHALL be registered and equal to (state==COOK) delayed by one cycle.

Reset
REQ-036 Asserting reset SHALL take effect asynchronously, in any state.
REQ-037 Reset SHALL force state IDLE and clear remaining_bcd, prescaler, PWM counter and latched heat level to 0.
REQ-038 Reset SHALL force heater_pwm, motor_on, busy, done and err to 0.
REQ-039 Release of reset SHALL be used synchronously; the first active edge after release evaluates from IDLE.

Structure
REQ-040 A shared package SHALL hold the state encodings, the PWM thresholds and the BCD digit limits, 9 and 5.
REQ-041 One sub-module, bcd_mmss_down, SHALL implement load, enable-decrement, clear and the zero flag.
REQ-042 The FSM, prescaler and PWM SHALL stay in cook_sequencer.

Verification (CLK_PER_SEC=4)
REQ-043 Start with duration 0005, level 1 -> LOAD then COOK; remaining_bcd steps 0004..0000 every 4 cycles; done rises at 0000; heater_pwm duty is 50%.
REQ-044 Start with 0100 -> after the first tick remaining_bcd=0059; with 1000 -> 0959.
REQ-045 Start with 0070 or 0000 -> one err pulse; state stays IDLE; busy stays 0.
REQ-046 door_open mid-second in COOK -> PAUSE; count and heater_pwm frozen/low; door closed plus start -> resume with the remaining partial second intact.
REQ-047 start and stop in the same cycle in COOK -> PAUSE; the same in PAUSE -> IDLE with 0000.
REQ-048 Reset asserted mid-COOK -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cook_sequencer_pkg.sv
// Shared definitions for the cook sequencer: state encodings, PWM thresholds
// and MMSS BCD digit limits.
package cook_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int unsigned BCD_W = 16;
  localparam int unsigned PWM_W = 8;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [3:0] BCD_STENS_MAX = 4'd5;

  localparam logic [PWM_W-1:0] PWM_THR_L0 = 8'd64;
  localparam logic [PWM_W-1:0] PWM_THR_L1 = 8'd128;
  localparam logic [PWM_W-1:0] PWM_THR_L2 = 8'd192;

  // MMSS is valid when every digit is decimal and seconds-tens is at most 5
  function automatic logic bcd_mmss_valid(input logic [BCD_W-1:0] v);
    return (v[15:12] <= BCD_DIGIT_MAX) && (v[11:8] <= BCD_DIGIT_MAX) &&
           (v[7:4] <= BCD_STENS_MAX) && (v[3:0] <= BCD_DIGIT_MAX);
  endfunction

  // Level 3 is forced high by the caller; its entry here is never used
  function automatic logic [PWM_W-1:0] pwm_threshold(input logic [1:0] lvl);
    case (lvl)
      2'd0:    return PWM_THR_L0;
      2'd1:    return PWM_THR_L1;
      default: return PWM_THR_L2;
    endcase
  endfunction

endpackage

// File: rtl/bcd_mmss_down.sv
// MMSS BCD down-counter: clear, load, enabled one-second decrement with
// digit borrow, and a zero flag.
module bcd_mmss_down
  import cook_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [BCD_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [BCD_W-1:0] value_o,
  output logic             zero_c
);

  logic [BCD_W-1:0] value_q, value_d;
  logic [3:0]       m1, m0, s1, s0;

  assign zero_c  = (value_q == '0);
  assign value_o = value_q;

  // Priority clear > load > decrement; decrement saturates at 0000
  always_comb begin
    value_d = value_q;
    m1 = value_q[15:12];
    m0 = value_q[11:8];
    s1 = value_q[7:4];
    s0 = value_q[3:0];
    if (clr_i) begin
      value_d = '0;
    end else if (load_i) begin
      value_d = load_val_i;
    end else if (dec_i && !zero_c) begin
      if (s0 != 4'd0) begin
        s0 = s0 - 4'd1;
      end else begin
        s0 = BCD_DIGIT_MAX;
        if (s1 != 4'd0) begin
          s1 = s1 - 4'd1;
        end else begin
          s1 = BCD_STENS_MAX;
          if (m0 != 4'd0) begin
            m0 = m0 - 4'd1;
          end else begin
            m0 = BCD_DIGIT_MAX;
            m1 = m1 - 4'd1;
          end
        end
      end
      value_d = {m1, m0, s1, s0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

endmodule

// File: rtl/cook_sequencer.sv
// Microwave cook sequencer: start/pause/resume/cancel FSM, one-second
// prescaler, MMSS countdown and heater PWM.
module cook_sequencer
  import cook_sequencer_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC = 50000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        door_open,
  input  logic [15:0] duration_bcd,
  input  logic [1:0]  heat_level,
  output logic        heater_pwm,
  output logic        motor_on,
  output logic [15:0] remaining_bcd,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  state
);

  localparam int unsigned PRESC_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(CLK_PER_SEC - 1);

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PWM_W-1:0]   pwm_cnt_q;
  logic [1:0]         heat_q;
  logic               heater_q, motor_q, busy_q, done_q, err_q, err_d;
  logic               load_c, clr_c, cook_run_c, tick_c, rem_zero_c;
  logic [BCD_W-1:0]   rem;

  // Stop or an open door freezes the second in progress
  assign cook_run_c = (state_q == ST_COOK) && !stop && !door_open;
  assign tick_c     = cook_run_c && (presc_q == PRESC_TC);

  bcd_mmss_down u_remaining (
    .clk        (clock),
    .rst_n      (reset),
    .clr_i      (clr_c),
    .load_i     (load_c),
    .load_val_i (duration_bcd),
    .dec_i      (tick_c),
    .value_o    (rem),
    .zero_c     (rem_zero_c)
  );

  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    clr_c   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!stop && start && !door_open) begin
          if (bcd_mmss_valid(duration_bcd) && (duration_bcd != '0)) state_d = ST_LOAD;
          else                                                     err_d   = 1'b1;
        end
      end
      ST_LOAD: begin
        load_c  = 1'b1;
        state_d = ST_COOK;
      end
      ST_COOK: begin
        if (stop || door_open)                                  state_d = ST_PAUSE;
        else if (rem_zero_c || (tick_c && rem == 16'h0001))     state_d = ST_DONE;
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
          clr_c   = 1'b1;
        end else if (start && !door_open) begin
          state_d = ST_COOK;
        end
      end
      ST_DONE: begin
        if (start || stop) begin
          state_d = ST_IDLE;
          clr_c   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    presc_d = presc_q;
    if (load_c || tick_c) presc_d = '0;
    else if (cook_run_c)  presc_d = presc_q + PRESC_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      heat_q    <= 2'd0;
      heater_q  <= 1'b0;
      motor_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      pwm_cnt_q <= (state_q == ST_COOK) ? pwm_cnt_q + PWM_W'(1) : '0;
      if (load_c) heat_q <= heat_level;
      heater_q  <= (state_q == ST_COOK) &&
                   ((heat_q == 2'd3) || (pwm_cnt_q < pwm_threshold(heat_q)));
      motor_q   <= (state_q == ST_COOK);
      busy_q    <= (state_d == ST_LOAD) || (state_d == ST_COOK) || (state_d == ST_PAUSE);
      done_q    <= (state_d == ST_DONE);
      err_q     <= err_d;
    end
  end

  assign heater_pwm    = heater_q;
  assign motor_on      = motor_q;
  assign remaining_bcd = rem;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign state         = 3'(state_q);

endmodule

// File: tb/tb_cook_sequencer.sv
// Scoreboard bench for cook_sequencer with a 4-cycle second.
module tb_cook_sequencer;

  localparam int unsigned CPS = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        door_open = 1'b0;
  logic [15:0] duration_bcd = 16'h0000;
  logic [1:0]  heat_level = 2'd0;
  logic        heater_pwm, motor_on, busy, done, err;
  logic [15:0] remaining_bcd;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  logic [2:0]  exp_state_q[$];
  logic [15:0] exp_rem_q[$];
  bit          exp_err_q[$];

  logic [2:0]  prev_state, mon_es;
  logic [15:0] prev_rem, mon_er;
  bit          mon_en = 1'b0;

  always #5 clock = ~clock;

  cook_sequencer #(.CLK_PER_SEC(CPS)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .door_open     (door_open),
    .duration_bcd  (duration_bcd),
    .heat_level    (heat_level),
    .heater_pwm    (heater_pwm),
    .motor_on      (motor_on),
    .remaining_bcd (remaining_bcd),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .state         (state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic int pending();
    return exp_state_q.size() + exp_rem_q.size() + exp_err_q.size();
  endfunction

  // Monitor: every observed state change, countdown change or err pulse
  // must match the next expected item
  always @(negedge clock) begin
    if (mon_en) begin
      if (state !== prev_state) begin
        if (exp_state_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL state_unexpected: got %0d expected no change at %0t", state, $time);
        end else begin
          mon_es = exp_state_q.pop_front();
          check("state", 32'(state), 32'(mon_es));
          check("busy", 32'(busy), 32'(mon_es == 3'd1 || mon_es == 3'd2 || mon_es == 3'd3));
          check("done", 32'(done), 32'(mon_es == 3'd4));
        end
        prev_state = state;
      end
      if (remaining_bcd !== prev_rem) begin
        if (exp_rem_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rem_unexpected: got %04h expected no change at %0t", remaining_bcd, $time);
        end else begin
          mon_er = exp_rem_q.pop_front();
          check("remaining", 32'(remaining_bcd), 32'(mon_er));
        end
        prev_rem = remaining_bcd;
      end
      if (err === 1'b1) begin
        checks++;
        if (exp_err_q.size() == 0) begin
          errors++;
          $display("FAIL err_unexpected: got 1 expected 0 at %0t", $time);
        end else begin
          void'(exp_err_q.pop_front());
        end
      end
    end
  end

  task automatic pulse(input logic s, input logic p);
    @(negedge clock);
    start = s;
    stop  = p;
    @(negedge clock);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (pending() != 0 && n < max_cyc) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("drain_pending", 32'(pending()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] bad_dur [4];
    logic [15:0] tick_in [2];
    logic [15:0] tick_out [2];
    int cyc, hi;
    bad_dur  = '{16'h0070, 16'h0000, 16'h0A00, 16'h00F1};
    tick_in  = '{16'h0100, 16'h1000};
    tick_out = '{16'h0059, 16'h0959};

    // Reset state
    #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_state", 32'(state), 32'd0);
    check("rst_rem", 32'(remaining_bcd), 32'd0);
    check("rst_heater", 32'(heater_pwm), 32'd0);
    check("rst_motor", 32'(motor_on), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b1;
    prev_state = state;
    prev_rem   = remaining_bcd;
    mon_en     = 1'b1;

    // 0005 at level 1: full countdown to DONE
    duration_bcd = 16'h0005; heat_level = 2'd1;
    exp_state_q.push_back(3'd1); exp_state_q.push_back(3'd2); exp_state_q.push_back(3'd4);
    for (int s = 5; s >= 0; s--) exp_rem_q.push_back(to_bcd(s));
    pulse(1'b1, 1'b0);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin @(negedge clock); cyc++; end
    check("done_latency", 32'(cyc), 32'd21);
    @(negedge clock);
    check("done_level", 32'(done), 32'd1);
    check("heater_after_cook", 32'(heater_pwm), 32'd0);
    check("motor_after_cook", 32'(motor_on), 32'd0);
    exp_state_q.push_back(3'd0);
    pulse(1'b0, 1'b1);
    wait_drain(5);

    // Rejected durations pulse err; door-open start is silently ignored
    for (int i = 0; i < 4; i++) begin
      duration_bcd = bad_dur[i];
      exp_err_q.push_back(1'b1);
      pulse(1'b1, 1'b0);
      @(negedge clock);
      check("bad_dur_state", 32'(state), 32'd0);
      check("bad_dur_busy", 32'(busy), 32'd0);
    end
    door_open = 1'b1; duration_bcd = 16'h0005;
    pulse(1'b1, 1'b0);
    repeat (2) @(negedge clock);
    check("door_start_state", 32'(state), 32'd0);
    door_open = 1'b0;
    wait_drain(3);

    // BCD borrow on the first tick, then pause and cancel
    for (int i = 0; i < 2; i++) begin
      duration_bcd = tick_in[i]; heat_level = 2'd2;
      exp_state_q.push_back(3'd1); exp_state_q.push_back(3'd2);
      exp_rem_q.push_back(tick_in[i]); exp_rem_q.push_back(tick_out[i]);
      pulse(1'b1, 1'b0);
      wait_drain(20);
      exp_state_q.push_back(3'd3);
      pulse(1'b0, 1'b1);
      exp_state_q.push_back(3'd0); exp_rem_q.push_back(16'h0000);
      pulse(1'b0, 1'b1);
      wait_drain(5);
    end

    // Door mid-second: pause, freeze, resume with the partial second kept
    duration_bcd = 16'h0003; heat_level = 2'd3;
    exp_state_q.push_back(3'd1); exp_state_q.push_back(3'd2);
    exp_rem_q.push_back(16'h0003);
    pulse(1'b1, 1'b0);
    repeat (3) @(negedge clock);
    exp_state_q.push_back(3'd3);
    door_open = 1'b1;
    repeat (2) @(negedge clock);
    check("pause_heater", 32'(heater_pwm), 32'd0);
    check("pause_motor", 32'(motor_on), 32'd0);
    pulse(1'b1, 1'b0);
    check("pause_door_start_state", 32'(state), 32'd3);
    check("pause_rem_hold", 32'(remaining_bcd), 32'h0003);
    door_open = 1'b0;
    exp_state_q.push_back(3'd2); exp_rem_q.push_back(16'h0002);
    pulse(1'b1, 1'b0);
    @(negedge clock);
    check("resume_rem_early", 32'(remaining_bcd), 32'h0003);
    check("resume_heater_l3", 32'(heater_pwm), 32'd1);
    check("resume_motor", 32'(motor_on), 32'd1);
    @(negedge clock);
    check("resume_partial_tick", 32'(remaining_bcd), 32'h0002);
    exp_rem_q.push_back(16'h0001); exp_rem_q.push_back(16'h0000);
    exp_state_q.push_back(3'd4);
    wait_drain(20);
    exp_state_q.push_back(3'd0);
    pulse(1'b1, 1'b0);
    wait_drain(5);

    // Start and stop together: stop wins in COOK and in PAUSE
    duration_bcd = 16'h0010;
    exp_state_q.push_back(3'd1); exp_state_q.push_back(3'd2);
    exp_rem_q.push_back(16'h0010);
    pulse(1'b1, 1'b0);
    wait_drain(10);
    exp_state_q.push_back(3'd3);
    pulse(1'b1, 1'b1);
    check("both_cook_rem", 32'(remaining_bcd), 32'h0010);
    exp_state_q.push_back(3'd0); exp_rem_q.push_back(16'h0000);
    pulse(1'b1, 1'b1);
    wait_drain(5);

    // Level 1 duty over 256 cook cycles; level change after LOAD ignored
    duration_bcd = 16'h0110; heat_level = 2'd1;
    exp_state_q.push_back(3'd1); exp_state_q.push_back(3'd2);
    exp_rem_q.push_back(16'h0110);
    for (int s = 69; s >= 6; s--) exp_rem_q.push_back(to_bcd(s));
    pulse(1'b1, 1'b0);
    @(negedge clock);
    heat_level = 2'd3;
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clock);
      if (heater_pwm === 1'b1) hi++;
    end
    check("duty_l1_high_cycles", 32'(hi), 32'd128);
    exp_state_q.push_back(3'd3);
    pulse(1'b0, 1'b1);
    exp_state_q.push_back(3'd0); exp_rem_q.push_back(16'h0000);
    pulse(1'b0, 1'b1);
    wait_drain(5);

    // Asynchronous reset in the middle of COOK
    duration_bcd = 16'h0005; heat_level = 2'd3;
    exp_state_q.push_back(3'd1); exp_state_q.push_back(3'd2);
    exp_rem_q.push_back(16'h0005);
    pulse(1'b1, 1'b0);
    wait_drain(10);
    @(negedge clock);
    check("pre_reset_heater", 32'(heater_pwm), 32'd1);
    check("pre_reset_motor", 32'(motor_on), 32'd1);
    @(posedge clock);
    #2;
    exp_state_q.push_back(3'd0); exp_rem_q.push_back(16'h0000);
    reset = 1'b0;
    #1;
    check("async_state", 32'(state), 32'd0);
    check("async_rem", 32'(remaining_bcd), 32'd0);
    check("async_heater", 32'(heater_pwm), 32'd0);
    check("async_motor", 32'(motor_on), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_done", 32'(done), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post_reset_state", 32'(state), 32'd0);
    wait_drain(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
